// File: rtl/kernel_sysinfo_pkg.sv
// Register map, control/status bit positions and CAPS word builder for kernel_sysinfo.
package kernel_sysinfo_pkg;

  typedef enum logic [2:0] {
    ADDR_ID      = 3'd0,
    ADDR_TS      = 3'd1,
    ADDR_UP_LO   = 3'd2,
    ADDR_UP_HI   = 3'd3,
    ADDR_SCRATCH = 3'd4,
    ADDR_CAPS    = 3'd5,
    ADDR_CTRL    = 3'd6,
    ADDR_STAT    = 3'd7
  } sysinfo_addr_e;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;
  localparam int STAT_FROZEN_BIT = 0;
  localparam int STAT_OVF_BIT    = 1;
  localparam int CAPS_UPTIME_BIT = 0;
  localparam int CAPS_CNTW_LSB   = 8;

  // The width field is only advertised when the uptime block is present.
  function automatic logic [31:0] caps_word(input int unsigned cnt_w, input logic uptime);
    logic [31:0] w;
    w = '0;
    if (uptime) begin
      w[CAPS_CNTW_LSB +: 8] = cnt_w[7:0];
      w[CAPS_UPTIME_BIT]    = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/kernel_sysinfo_uptime.sv
// Free-running uptime counter with clear/freeze, sticky wrap flag and high-word shadow capture.
module kernel_sysinfo_uptime
  import kernel_sysinfo_pkg::*;
#(
  parameter int CNT_W = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        freeze,
  input  logic        ovf_clr,
  input  logic        lo_rd,
  output logic [31:0] count_lo,
  output logic [31:0] shadow,
  output logic        ovf
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic             wrap;

  assign wrap     = !clear && !freeze && (&count);
  assign count_lo = count[31:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!freeze) begin
      count <= count + ONE;
    end
  end

  // Shadow takes the pre-update high word so UP_LO and UP_HI form one coherent sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (lo_rd) begin
      shadow <= 32'(count >> 32);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/kernel_sysinfo.sv
// Avalon-MM system ID / uptime slave; the uptime block exists only when SYSINFO_UPTIME_EN is defined.
module kernel_sysinfo
  import kernel_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSID_ID = 32'h586E_1B3E,
  parameter logic [31:0] SYSID_TS = 32'h0,
  parameter int          CNT_W    = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  sysinfo_addr_e addr;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   scratch;
  logic [31:0]   rd_mux;
  logic          freeze;
  logic          ovf;
  logic [31:0]   count_lo;
  logic [31:0]   shadow;

  assign addr  = sysinfo_addr_e'(address);
  assign rd_en = chipselect && read;
  assign wr_en = chipselect && write;

`ifdef SYSINFO_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;

  logic clear;
  logic ovf_clr;
  logic lo_rd;

  assign clear   = wr_en && (addr == ADDR_CTRL) && writedata[CTRL_CLEAR_BIT];
  assign ovf_clr = wr_en && (addr == ADDR_STAT) && writedata[STAT_OVF_BIT];
  assign lo_rd   = rd_en && (addr == ADDR_UP_LO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze <= 1'b0;
    end else if (wr_en && (addr == ADDR_CTRL)) begin
      freeze <= writedata[CTRL_FREEZE_BIT];
    end
  end

  kernel_sysinfo_uptime #(
    .CNT_W (CNT_W)
  ) u_uptime (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .freeze   (freeze),
    .ovf_clr  (ovf_clr),
    .lo_rd    (lo_rd),
    .count_lo (count_lo),
    .shadow   (shadow),
    .ovf      (ovf)
  );
`else
  localparam logic UPTIME_PRESENT = 1'b0;

  assign freeze   = 1'b0;
  assign ovf      = 1'b0;
  assign count_lo = '0;
  assign shadow   = '0;
`endif

  localparam logic [31:0] CAPS = caps_word(CNT_W, UPTIME_PRESENT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (wr_en && (addr == ADDR_SCRATCH)) begin
      scratch <= writedata;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_ID:      rd_mux = SYSID_ID;
      ADDR_TS:      rd_mux = SYSID_TS;
      ADDR_UP_LO:   rd_mux = count_lo;
      ADDR_UP_HI:   rd_mux = shadow;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_CAPS:    rd_mux = CAPS;
      ADDR_CTRL:    rd_mux[CTRL_FREEZE_BIT] = freeze;
      ADDR_STAT: begin
        rd_mux[STAT_FROZEN_BIT] = freeze;
        rd_mux[STAT_OVF_BIT]    = ovf;
      end
      default:      rd_mux = '0;
    endcase
  end

  // Fixed one-cycle read latency; reset kills any response in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_en;
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_kernel_sysinfo.sv
// Scoreboard bench for kernel_sysinfo; uptime scenarios are built when SYSINFO_UPTIME_EN is defined.
module tb_kernel_sysinfo;
  import kernel_sysinfo_pkg::*;

  localparam logic [31:0] ID_VAL = 32'h586E_1B3E;
  localparam logic [31:0] TS_VAL = 32'h0;
  localparam int          CNT_W  = 48;
`ifdef SYSINFO_UPTIME_EN
  localparam logic [31:0] CAPS_EXP = 32'h0000_3001;
`else
  localparam logic [31:0] CAPS_EXP = 32'h0000_0000;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;
  int pulses = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          acc_q[$];
  logic [31:0] rd_q[$];
  int          rv_q[$];

  kernel_sysinfo #(
    .SYSID_ID (ID_VAL),
    .SYSID_TS (TS_VAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  // Response monitor: samples 1 time unit after each rising edge.
  always @(posedge clock) begin
    cycle++;
    #1;
    if (readdatavalid === 1'b1) begin
      rd_q.push_back(readdata);
      rv_q.push_back(cycle);
      pulses++;
    end
  end

  task automatic issue_read(input logic [2:0] a, input bit chk, input logic [31:0] e, input string nm);
    @(negedge clock);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
      acc_q.push_back(cycle + 1);
    end
  endtask

  task automatic issue_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clock);
    chipselect = 1'b1; read = 1'b0; write = 1'b1; address = a; writedata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic [31:0] got, e;
    string nm;
    int a, rc, p0;
    repeat (2) @(negedge clock);
    chipselect = 1'b1; read = 1'b1; address = ADDR_SCRATCH;
    repeat (2) @(posedge clock);
    #2;
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0)
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h expected valid=0 data=0", readdatavalid, readdata);
    else passed++;
    total++;
    if (pulses != 0) $display("[TB] FAIL reset_no_pulse: got %0d pulses expected 0", pulses);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1; chipselect = 1'b0; read = 1'b0;
    p0 = pulses;
    issue_read(ADDR_ID, 1, ID_VAL, "id_read");
    issue_read(ADDR_TS, 1, TS_VAL, "ts_read");
    issue_read(ADDR_CAPS, 1, CAPS_EXP, "caps_read");
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
        total++;
        if (rc != a) $display("[TB] FAIL %s_latency: got cycle %0d expected cycle %0d", nm, rc, a);
        else passed++;
      end
    end
    total++;
    if (pulses - p0 != 3) $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", pulses - p0);
    else passed++;
    rd_q.delete(); rv_q.delete();
  endtask

  task automatic test_scratch;
    logic [31:0] got, e;
    string nm;
    int a, rc, p0;
    issue_write(ADDR_SCRATCH, 32'hDEAD_BEEF);
    issue_read(ADDR_SCRATCH, 1, 32'hDEAD_BEEF, "scratch_next_cycle");
    issue_write(ADDR_ID, 32'h1234_5678);
    issue_write(ADDR_TS, 32'hFFFF_FFFF);
    issue_write(ADDR_CAPS, 32'hFFFF_FFFF);
    issue_read(ADDR_ID, 1, ID_VAL, "id_after_write");
    issue_read(ADDR_TS, 1, TS_VAL, "ts_after_write");
    issue_read(ADDR_CAPS, 1, CAPS_EXP, "caps_after_write");
    issue_write(ADDR_SCRATCH, 32'h0F0F_A5A5);
    issue_read(ADDR_SCRATCH, 1, 32'h0F0F_A5A5, "scratch_overwrite");
    @(negedge clock);
    chipselect = 1'b0; read = 1'b0; write = 1'b1; address = ADDR_SCRATCH; writedata = 32'h1111_2222;
    issue_read(ADDR_SCRATCH, 1, 32'h0F0F_A5A5, "scratch_cs_low_write");
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    total++;
    if (rd_q.size() != 0) $display("[TB] FAIL scratch_extra_resp: got %0d expected 0", rd_q.size());
    else passed++;
    rd_q.delete(); rv_q.delete();
    p0 = pulses;
    @(negedge clock);
    chipselect = 1'b0; read = 1'b1; write = 1'b0; address = ADDR_ID;
    idle(3);
    total++;
    if (pulses != p0) $display("[TB] FAIL cs_low_read: got %0d pulses expected 0", pulses - p0);
    else passed++;
    rd_q.delete(); rv_q.delete();
  endtask

`ifdef SYSINFO_UPTIME_EN
  task automatic test_freeze_clear;
    logic [31:0] got, e, v1, v2, v3, v4, v5;
    string nm;
    int a, rc;
    issue_write(ADDR_CTRL, 32'h2);
    issue_read(ADDR_CTRL, 1, 32'h2, "ctrl_freeze");
    issue_read(ADDR_STAT, 1, 32'h1, "stat_frozen");
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    rd_q.delete(); rv_q.delete();
    issue_read(ADDR_UP_LO, 0, 0, "");
    idle(10);
    issue_read(ADDR_UP_LO, 0, 0, "");
    issue_write(ADDR_CTRL, 32'h0);
    issue_read(ADDR_UP_LO, 0, 0, "");
    issue_read(ADDR_UP_LO, 0, 0, "");
    issue_write(ADDR_CTRL, 32'h1);
    issue_read(ADDR_UP_LO, 0, 0, "");
    idle(2);
    total++;
    if (rd_q.size() != 5) $display("[TB] FAIL uptime_resp_count: got %0d expected 5", rd_q.size());
    else begin
      passed++;
      v1 = rd_q.pop_front(); v2 = rd_q.pop_front(); v3 = rd_q.pop_front();
      v4 = rd_q.pop_front(); v5 = rd_q.pop_front();
      total++;
      if (v2 !== v1) $display("[TB] FAIL frozen_stable: got %h expected %h", v2, v1);
      else passed++;
      total++;
      if (v3 !== v1) $display("[TB] FAIL unfreeze_edge: got %h expected %h", v3, v1);
      else passed++;
      total++;
      if (v4 !== v3 + 32'd1) $display("[TB] FAIL count_step: got %h expected %h", v4, v3 + 32'd1);
      else passed++;
      total++;
      if (v5 > 32'd1) $display("[TB] FAIL clear_running: got %h expected 0 or 1", v5);
      else passed++;
    end
    rd_q.delete(); rv_q.delete();
    issue_write(ADDR_CTRL, 32'h3);
    issue_read(ADDR_UP_LO, 1, 32'h0, "clear_frozen_lo");
    issue_read(ADDR_CTRL, 1, 32'h2, "ctrl_clear_reads0");
    issue_read(ADDR_UP_LO, 1, 32'h0, "clear_frozen_hold");
    issue_write(ADDR_CTRL, 32'h0);
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    rd_q.delete(); rv_q.delete();
  endtask

  task automatic test_wrap_shadow;
    logic [31:0] got, e;
    string nm;
    int a, rc;
    @(posedge clock);
    #2;
    force dut.u_uptime.count = 48'h0000_FFFF_FFFF;
    #1;
    release dut.u_uptime.count;
    issue_read(ADDR_UP_LO, 1, 32'hFFFF_FFFF, "lo_before_carry");
    issue_read(ADDR_UP_HI, 1, 32'h0, "hi_coherent_0");
    issue_read(ADDR_UP_LO, 1, 32'h1, "lo_after_carry");
    issue_read(ADDR_UP_HI, 1, 32'h1, "hi_coherent_1");
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    rd_q.delete(); rv_q.delete();
  endtask

  task automatic test_ovf;
    logic [31:0] got, e;
    string nm;
    int a, rc;
    issue_read(ADDR_STAT, 1, 32'h0, "stat_clean");
    idle(2);
    @(posedge clock);
    #2;
    force dut.u_uptime.count = {CNT_W{1'b1}};
    #1;
    release dut.u_uptime.count;
    issue_read(ADDR_STAT, 1, 32'h0, "stat_at_wrap_edge");
    issue_read(ADDR_STAT, 1, 32'h2, "ovf_set");
    issue_write(ADDR_STAT, 32'h2);
    issue_read(ADDR_STAT, 1, 32'h0, "ovf_w1c");
    idle(1);
    @(posedge clock);
    #2;
    force dut.u_uptime.count = {CNT_W{1'b1}};
    #1;
    release dut.u_uptime.count;
    issue_write(ADDR_STAT, 32'h2);
    issue_read(ADDR_STAT, 1, 32'h2, "ovf_set_beats_clr");
    issue_write(ADDR_CTRL, 32'h1);
    issue_read(ADDR_STAT, 1, 32'h2, "ovf_survives_clear");
    issue_write(ADDR_STAT, 32'h2);
    issue_read(ADDR_STAT, 1, 32'h0, "ovf_w1c_again");
    issue_write(ADDR_CTRL, 32'h2);
    @(posedge clock);
    #2;
    force dut.u_uptime.count = {CNT_W{1'b1}};
    #1;
    release dut.u_uptime.count;
    idle(3);
    issue_read(ADDR_STAT, 1, 32'h1, "frozen_no_ovf");
    issue_write(ADDR_CTRL, 32'h0);
    idle(2);
    issue_read(ADDR_STAT, 1, 32'h2, "ovf_after_unfreeze");
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    rd_q.delete(); rv_q.delete();
  endtask
`else
  task automatic test_disabled;
    logic [31:0] got, e;
    string nm;
    int a, rc;
    issue_write(ADDR_UP_LO, 32'hFFFF_FFFF);
    issue_write(ADDR_UP_HI, 32'hFFFF_FFFF);
    issue_write(ADDR_CTRL, 32'hFFFF_FFFF);
    issue_write(ADDR_STAT, 32'hFFFF_FFFF);
    idle(4);
    issue_read(ADDR_UP_LO, 1, 32'h0, "dis_up_lo");
    issue_read(ADDR_UP_HI, 1, 32'h0, "dis_up_hi");
    issue_read(ADDR_CTRL, 1, 32'h0, "dis_ctrl");
    issue_read(ADDR_STAT, 1, 32'h0, "dis_stat");
    issue_read(ADDR_CAPS, 1, 32'h0, "dis_caps");
    issue_write(ADDR_SCRATCH, 32'h0BAD_F00D);
    issue_read(ADDR_SCRATCH, 1, 32'h0BAD_F00D, "dis_scratch");
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    rd_q.delete(); rv_q.delete();
  endtask
`endif

  task automatic test_reset_mid_read;
    logic [31:0] got, e;
    string nm;
    int a, rc, p0;
    issue_write(ADDR_SCRATCH, 32'hCAFE_F00D);
    issue_read(ADDR_SCRATCH, 0, 0, "");
    @(posedge clock);
    #3;
    total++;
    if (readdatavalid !== 1'b1 || readdata !== 32'hCAFE_F00D)
      $display("[TB] FAIL pre_reset_resp: got valid=%b data=%h expected valid=1 data=cafef00d", readdatavalid, readdata);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0)
      $display("[TB] FAIL async_reset_kill: got valid=%b data=%h expected valid=0 data=0", readdatavalid, readdata);
    else passed++;
    p0 = pulses;
    repeat (2) @(negedge clock);
    total++;
    if (pulses != p0) $display("[TB] FAIL reset_pending: got %0d pulses expected 0", pulses - p0);
    else passed++;
    reset_n = 1'b1; chipselect = 1'b0; read = 1'b0;
    rd_q.delete(); rv_q.delete();
    issue_read(ADDR_SCRATCH, 1, 32'h0, "scratch_after_reset");
    issue_read(ADDR_ID, 1, ID_VAL, "id_after_reset");
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); a = acc_q.pop_front();
      total++;
      if (rd_q.size() == 0) $display("[TB] FAIL %s: no response expected %h", nm, e);
      else begin
        got = rd_q.pop_front(); rc = rv_q.pop_front();
        if (got !== e) $display("[TB] FAIL %s: got %h expected %h", nm, got, e);
        else passed++;
      end
    end
    rd_q.delete(); rv_q.delete();
  endtask

  initial begin
    $display("[TB] kernel_sysinfo bench start");
    test_reset();
    test_scratch();
`ifdef SYSINFO_UPTIME_EN
    test_freeze_clear();
    test_wrap_shadow();
    test_ovf();
`else
    test_disabled();
`endif
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
